fb_cmd_store: RTL and testbench
===============================

// Module: fb_cmd_store
// PURPOSE
// - Framebuffer and command front end directly upstream of the HDMI renderer (testpattern).
// - Parses a byte stream of host commands, e.g. from the UART receiver.
// - Stores a 90x90, 2-bit-per-pixel image in on-chip RAM.
// - Serves renderer reads: O_pixel_colour from I_pixel_address.
// - Drives the renderer's bgcolour and palette inputs.
// PARAMETERS
// - FB_W    90  pixels per line
// - FB_H    90  lines; FB_SIZE = FB_W*FB_H = 8100
// - ADDR_W  13  pixel address width
// PORTS
// - I_pxl_clk        in   1       pixel clock; sole clock domain
// - I_rst_n          in   1       asynchronous, active-low reset
// - I_rx_data        in   8       command/data byte
// - I_rx_valid       in   1       I_rx_data valid
// - O_rx_ready       out  1       byte accepted on cycles where I_rx_valid & O_rx_ready
// - I_pixel_address  in   ADDR_W  renderer read address, row-major (FB_W*y + x)
// - O_pixel_colour   out  2       colour index at I_pixel_address
// - O_bgcolour       out  24      background colour, packed {B,G,R}
// - O_palette        out  2       palette select
// - I_vs             in   1       renderer VS, active-high; used only with FB_VS_COMMIT_EN
// - O_busy           out  1       high while unpacking or filling
// - O_err            out  1       one-cycle error pulse
// BEHAVIOUR
// - Reset values: O_rx_ready=1, O_pixel_colour=0, O_bgcolour=0, O_palette=0, O_busy=0, O_err=0.
// - Reset also sets: write pointer=0, FSM=IDLE. RAM contents are not reset.
// - Read port:
//   - O_pixel_colour is registered: mem[I_pixel_address] appears 1 cycle after the address.
//   - Addresses >= FB_SIZE read 2'b00.
//   - A same-address read and write in one cycle returns the old data.
// - Opcodes, accepted in IDLE:
//   - 0xA0 SET_ADDR: next 2 bytes are hi[4:0], then lo. A result >= FB_SIZE loads 0 and pulses O_err.
//   - 0xA1 WRITE: next byte is count N (0 means 256), then N data bytes.
//     - Each data byte holds 4 pixels, bits[7:6] first.
//     - Pixels are written at the pointer, which post-increments.
//   - 0xA2 SET_BG: next 3 bytes are R, G, B, held in a shadow register.
//     - The value goes to O_bgcolour on the cycle after the B byte is accepted.
//   - 0xA3 SET_PAL: next byte; bits[1:0] go to O_palette the cycle after acceptance.
//   - 0xA4 CLEAR: next byte; bits[1:0] are written to all FB_SIZE pixels, one per cycle from address 0.
//     - The pointer is 0 afterwards.
//   - Any other byte in IDLE: discarded, 1-cycle O_err pulse, FSM stays in IDLE.
// - FSM states: IDLE, ADDR_HI, ADDR_LO, CNT, DATA, UNPACK, BG_R, BG_G, BG_B, PAL, CLR_IDX, FILL.
//   - Each byte-taking state advances by one state per accepted byte.
//   - DATA -> UNPACK: 4 cycles, one pixel written per cycle. O_rx_ready=0 and O_busy=1 throughout.
//   - After UNPACK: back to DATA if bytes remain, else IDLE. Throughput is 1 byte per 5 cycles.
//   - FILL: FB_SIZE cycles with O_rx_ready=0 and O_busy=1, then IDLE.
// - Pointer wrap: incrementing past FB_SIZE-1 gives 0, with no error.
// - Bytes are never dropped while O_rx_ready=1.
// - Reset asserted mid-command aborts to IDLE. Partially written pixels remain in RAM.
// CONFIGURATION
// - FB_VS_COMMIT_EN defined:
//   - SET_BG and SET_PAL update shadow registers only.
//   - O_bgcolour and O_palette load from the shadows on the cycle after an I_vs rising edge, so there is no tearing mid-frame.
//   - Several updates inside one frame: the last one wins.
// - FB_VS_COMMIT_EN undefined:
//   - Updates take effect immediately as described above.
//   - I_vs is ignored.
// TESTING
// - Reset -> O_rx_ready=1, O_bgcolour=0, O_palette=0, O_busy=0, O_err=0.
// - A0 00 05, A1 01 E4 -> pixels 5,6,7,8 = 3,2,1,0; read addr 6 -> O_pixel_colour=2 one cycle later.
//   Also check: O_rx_ready low for 4 cycles after byte E4.
// - A0 1F 9F (8095), A1 02 FF FF -> pixels 8095..8099 and 0..2 = 3; pointer ends at 3.
// - A2 10 20 30 -> O_bgcolour=24'h302010. A3 03 -> O_palette=3.
//   With FB_VS_COMMIT_EN: both stay 0 until the cycle after the I_vs rise.
// - A4 02 -> O_busy high for exactly 8100 cycles; afterwards reads of 0, 4050, 8099 = 2.
// - Byte 0x55 in IDLE -> single O_err pulse, no state change.
//   Also: A0 1F FF -> pointer=0 plus O_err. Reset mid-WRITE -> next A3 01 is accepted normally.

Source files
------------

// File: rtl/fb_cmd_store.sv
// Command parser + 90x90x2bpp framebuffer feeding the HDMI renderer.
// Optional FB_VS_COMMIT_EN: bgcolour/palette commit on the I_vs rising edge.
module fb_cmd_store #(
    parameter int FB_W   = 90,
    parameter int FB_H   = 90,
    parameter int ADDR_W = 13
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst_n,
    input  logic [7:0]        I_rx_data,
    input  logic              I_rx_valid,
    output logic              O_rx_ready,
    input  logic [ADDR_W-1:0] I_pixel_address,
    output logic [1:0]        O_pixel_colour,
    output logic [23:0]       O_bgcolour,
    output logic [1:0]        O_palette,
    input  logic              I_vs,
    output logic              O_busy,
    output logic              O_err
);

    localparam int FB_SIZE = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_SIZE - 1);
    localparam logic [ADDR_W-1:0] SIZE = ADDR_W'(FB_SIZE);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_CNT, S_DATA, S_UNPACK,
        S_BG_R, S_BG_G, S_BG_B, S_PAL, S_CLR_IDX, S_FILL
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [8:0]        cnt, cnt_n;
    logic [7:0]        sh, sh_n;
    logic [1:0]        sub, sub_n;
    logic [4:0]        hi, hi_n;
    logic [7:0]        sh_r, sh_r_n, sh_g, sh_g_n;
    logic [23:0]       bg_sh, bg_sh_n;
    logic [1:0]        pal_sh, pal_sh_n;
    logic [1:0]        idx, idx_n;
    logic              err_n, bg_load, pal_load;
    logic              accept;
    logic              we;
    logic [1:0]        wdata;
    logic [ADDR_W-1:0] lo_addr;

    logic [1:0] mem [0:FB_SIZE-1];

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign O_rx_ready = (state != S_UNPACK) && (state != S_FILL);
    assign O_busy     = !O_rx_ready;
    assign accept     = I_rx_valid && O_rx_ready;
    assign lo_addr    = {hi, I_rx_data};

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        sh_n     = sh;
        sub_n    = sub;
        hi_n     = hi;
        sh_r_n   = sh_r;
        sh_g_n   = sh_g;
        bg_sh_n  = bg_sh;
        pal_sh_n = pal_sh;
        idx_n    = idx;
        err_n    = 1'b0;
        bg_load  = 1'b0;
        pal_load = 1'b0;
        we       = 1'b0;
        wdata    = '0;
        case (state)
            S_IDLE: if (accept) begin
                case (I_rx_data)
                    8'hA0:   state_n = S_ADDR_HI;
                    8'hA1:   state_n = S_CNT;
                    8'hA2:   state_n = S_BG_R;
                    8'hA3:   state_n = S_PAL;
                    8'hA4:   state_n = S_CLR_IDX;
                    default: err_n   = 1'b1;
                endcase
            end
            S_ADDR_HI: if (accept) begin
                hi_n    = I_rx_data[4:0];
                state_n = S_ADDR_LO;
            end
            S_ADDR_LO: if (accept) begin
                if (lo_addr >= SIZE) begin
                    ptr_n = '0;
                    err_n = 1'b1;
                end else begin
                    ptr_n = lo_addr;
                end
                state_n = S_IDLE;
            end
            S_CNT: if (accept) begin
                cnt_n   = (I_rx_data == 8'd0) ? 9'd256 : {1'b0, I_rx_data};
                state_n = S_DATA;
            end
            S_DATA: if (accept) begin
                sh_n    = I_rx_data;
                sub_n   = '0;
                state_n = S_UNPACK;
            end
            S_UNPACK: begin
                we    = 1'b1;
                wdata = sh[7:6];
                sh_n  = {sh[5:0], 2'b00};
                sub_n = sub + 2'd1;
                ptr_n = ptr_inc(ptr);
                if (sub == 2'd3) begin
                    if (cnt == 9'd1) begin
                        state_n = S_IDLE;
                    end else begin
                        cnt_n   = cnt - 9'd1;
                        state_n = S_DATA;
                    end
                end
            end
            S_BG_R: if (accept) begin
                sh_r_n  = I_rx_data;
                state_n = S_BG_G;
            end
            S_BG_G: if (accept) begin
                sh_g_n  = I_rx_data;
                state_n = S_BG_B;
            end
            S_BG_B: if (accept) begin
                bg_sh_n = {I_rx_data, sh_g, sh_r};
                bg_load = 1'b1;
                state_n = S_IDLE;
            end
            S_PAL: if (accept) begin
                pal_sh_n = I_rx_data[1:0];
                pal_load = 1'b1;
                state_n  = S_IDLE;
            end
            S_CLR_IDX: if (accept) begin
                idx_n   = I_rx_data[1:0];
                ptr_n   = '0;
                state_n = S_FILL;
            end
            S_FILL: begin
                we    = 1'b1;
                wdata = idx;
                // the fill walks the pointer itself, so its final wrap leaves it at 0
                ptr_n = ptr_inc(ptr);
                if (ptr == LAST) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state  <= S_IDLE;
            ptr    <= '0;
            cnt    <= '0;
            sh     <= '0;
            sub    <= '0;
            hi     <= '0;
            sh_r   <= '0;
            sh_g   <= '0;
            bg_sh  <= '0;
            pal_sh <= '0;
            idx    <= '0;
            O_err  <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            sh     <= sh_n;
            sub    <= sub_n;
            hi     <= hi_n;
            sh_r   <= sh_r_n;
            sh_g   <= sh_g_n;
            bg_sh  <= bg_sh_n;
            pal_sh <= pal_sh_n;
            idx    <= idx_n;
            O_err  <= err_n;
        end
    end

`ifdef FB_VS_COMMIT_EN
    logic vs_q;
    logic unused_loads;
    assign unused_loads = bg_load ^ pal_load;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            vs_q       <= 1'b0;
            O_bgcolour <= '0;
            O_palette  <= '0;
        end else begin
            vs_q <= I_vs;
            if (I_vs && !vs_q) begin
                O_bgcolour <= bg_sh;
                O_palette  <= pal_sh;
            end
        end
    end
`else
    logic vs_unused;
    assign vs_unused = I_vs;

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_bgcolour <= '0;
            O_palette  <= '0;
        end else begin
            if (bg_load)  O_bgcolour <= bg_sh_n;
            if (pal_load) O_palette  <= pal_sh_n;
        end
    end
`endif

    // RAM kept free of reset so it maps onto block memory
    always_ff @(posedge I_pxl_clk) begin
        if (we) mem[ptr] <= wdata;
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_pixel_colour <= '0;
        end else if (I_pixel_address < SIZE) begin
            O_pixel_colour <= mem[I_pixel_address];
        end else begin
            O_pixel_colour <= '0;
        end
    end

endmodule

// File: tb/tb_fb_cmd_store.sv
// Randomized self-checking bench for fb_cmd_store against a command-level model.
module tb_fb_cmd_store;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [12:0] pix_addr = '0;
    logic [1:0]  pix_col;
    logic [23:0] bgcolour;
    logic [1:0]  palette;
    logic        vs = 1'b0;
    logic        busy, err;

    fb_cmd_store #(.FB_W(90), .FB_H(90), .ADDR_W(13)) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_rx_data(rx_data), .I_rx_valid(rx_valid),
        .O_rx_ready(rx_ready), .I_pixel_address(pix_addr), .O_pixel_colour(pix_col),
        .O_bgcolour(bgcolour), .O_palette(palette), .I_vs(vs), .O_busy(busy), .O_err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int err_seen = 0, busy_seen = 0;
    always @(negedge clk) begin
        if (err)  err_seen++;
        if (busy) busy_seen++;
    end

    // reference model: whole commands applied once complete
    logic [1:0]  m_mem [0:8099];
    int          m_ptr = 0;
    logic [7:0]  cq[$];
    logic [23:0] m_bg = '0, m_bg_sh = '0;
    logic [1:0]  m_pal = '0, m_pal_sh = '0;
    int          m_err = 0;

    function automatic void model_byte(input logic [7:0] b);
        int a, n;
        cq.push_back(b);
        case (cq[0])
            8'hA0: if (cq.size() == 3) begin
                a = int'(cq[1] & 8'h1F) * 256 + int'(cq[2]);
                if (a >= 8100) begin m_ptr = 0; m_err++; end
                else m_ptr = a;
                cq.delete();
            end
            8'hA1: if (cq.size() >= 2) begin
                n = (cq[1] == 0) ? 256 : int'(cq[1]);
                if (cq.size() > 2) begin
                    for (int k = 0; k < 4; k++) begin
                        m_mem[m_ptr] = b[7-2*k -: 2];
                        m_ptr = (m_ptr + 1) % 8100;
                    end
                    if (cq.size() == n + 2) cq.delete();
                end
            end
            8'hA2: if (cq.size() == 4) begin
                m_bg_sh = {cq[3], cq[2], cq[1]};
`ifndef FB_VS_COMMIT_EN
                m_bg = m_bg_sh;
`endif
                cq.delete();
            end
            8'hA3: if (cq.size() == 2) begin
                m_pal_sh = cq[1][1:0];
`ifndef FB_VS_COMMIT_EN
                m_pal = m_pal_sh;
`endif
                cq.delete();
            end
            8'hA4: if (cq.size() == 2) begin
                for (int k = 0; k < 8100; k++) m_mem[k] = b[1:0];
                m_ptr = 0;
                cq.delete();
            end
            default: begin m_err++; cq.delete(); end
        endcase
    endfunction

    function automatic void model_reset();
        m_ptr = 0; cq.delete();
        m_bg = '0; m_bg_sh = '0; m_pal = '0; m_pal_sh = '0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (!rx_ready && t < 20000) begin @(negedge clk); t++; end
        if (t >= 20000) check_eq("send_timeout", 32'(t), 0);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk);
        model_byte(b);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 20000) begin @(negedge clk); t++; end
        if (t >= 20000) check_eq("idle_timeout", 32'(t), 0);
        @(negedge clk);
    endtask

    task automatic rd(input int a, output logic [1:0] v);
        @(negedge clk); pix_addr = 13'(a);
        @(negedge clk); v = pix_col;
    endtask

    function automatic logic [1:0] m_rd(input int a);
        return (a < 8100) ? m_mem[a] : 2'b00;
    endfunction

    task automatic vs_pulse();
        @(negedge clk); vs = 1'b1;
        @(posedge clk);
`ifdef FB_VS_COMMIT_EN
        m_bg = m_bg_sh; m_pal = m_pal_sh;
`endif
        #1;
        @(negedge clk); vs = 1'b0;
    endtask

    task automatic send_addr(input int a);
        logic [12:0] av;
        av = 13'(a);
        send(8'hA0); send(8'(av[12:8])); send(av[7:0]);
    endtask

    logic [1:0] v;
    int e0, b0, n, a, r;
    logic [7:0] op;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_ready", rx_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bg", bgcolour, 0);
        check_eq("rst_pal", palette, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_col", pix_col, 0);
        @(negedge clk) rst_n = 1'b1;

        // single byte write, ready drop for unpack
        send_addr(5); send(8'hA1); send(8'h01); send(8'hE4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); check_eq("unpack_ready_low", rx_ready, 0);
        end
        @(negedge clk); check_eq("unpack_ready_back", rx_ready, 1);
        for (int k = 0; k < 4; k++) begin
            rd(5 + k, v); check_eq("px5_8", v, 32'(3 - k));
        end

        // pointer wrap across end of buffer
        send_addr(8095); send(8'hA1); send(8'h02); send(8'hFF); send(8'hFF);
        wait_idle();
        rd(8099, v); check_eq("wrap_8099", v, 3);
        rd(2, v);    check_eq("wrap_2", v, 3);
        send(8'hA1); send(8'h01); send(8'h00);
        wait_idle();
        rd(3, v); check_eq("ptr_end3", v, 0);
        rd(2, v); check_eq("ptr_keep2", v, 3);

        // background / palette
        send(8'hA2); send(8'h10); send(8'h20); send(8'h30);
        check_eq("bg_pre", bgcolour, 32'(m_bg));
        send(8'hA3); send(8'h03);
        check_eq("pal_pre", palette, 32'(m_pal));
        vs_pulse();
        check_eq("bg_val", bgcolour, 32'h302010);
        check_eq("pal_val", palette, 3);

        // errors
        e0 = err_seen;
        send(8'h55); wait_idle();
        check_eq("bad_op_err", 32'(err_seen - e0), 1);
        check_eq("bad_op_ready", rx_ready, 1);
        e0 = err_seen;
        send(8'hA0); send(8'h1F); send(8'hFF); wait_idle();
        check_eq("oor_addr_err", 32'(err_seen - e0), 1);
        send(8'hA1); send(8'h01); send(8'h40); wait_idle();
        rd(0, v); check_eq("oor_ptr0", v, 1);
        rd(1, v); check_eq("oor_ptr1", v, 0);

        // clear
        b0 = busy_seen;
        send(8'hA4); send(8'h02); wait_idle();
        check_eq("fill_busy_cycles", 32'(busy_seen - b0), 8100);
        rd(0, v);    check_eq("clr_0", v, 2);
        rd(4050, v); check_eq("clr_4050", v, 2);
        rd(8099, v); check_eq("clr_8099", v, 2);

        // randomized command mix
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                send_addr($urandom_range(0, 8099));
                n = (i == 3) ? 0 : $urandom_range(1, 6);
                send(8'hA1); send(8'(n));
                for (int k = 0; k < ((n == 0) ? 256 : n); k++) send(8'($urandom));
            end else if (r == 5) begin
                send(8'hA2); send(8'($urandom)); send(8'($urandom)); send(8'($urandom));
            end else if (r == 6) begin
                send(8'hA3); send(8'($urandom));
            end else if (r == 7) begin
                op = 8'($urandom);
                while (op >= 8'hA0 && op <= 8'hA4) op = 8'($urandom);
                send(op);
            end else if (r == 8) begin
                send(8'hA0); send(8'h1F); send(8'($urandom_range(8'hA4, 8'hFF)));
            end else begin
                send(8'hA1); send(8'h02); send(8'($urandom)); send(8'($urandom));
            end
        end
        wait_idle();
        check_eq("rnd_err_count", 32'(err_seen), 32'(m_err));
        check_eq("rnd_bg", bgcolour, 32'(m_bg));
        check_eq("rnd_pal", palette, 32'(m_pal));
        vs_pulse();
        check_eq("rnd_bg_commit", bgcolour, 32'(m_bg));
        check_eq("rnd_pal_commit", palette, 32'(m_pal));
        for (int i = 0; i < 80; i++) begin
            a = (i % 10 == 9) ? $urandom_range(8100, 8191) : $urandom_range(0, 8099);
            rd(a, v); check_eq("rnd_read", v, 32'(m_rd(a)));
        end

        // reset in the middle of a write
        send_addr(100); send(8'hA1); send(8'h05); send(8'h1B);
        @(negedge clk); rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", rx_ready, 1);
        check_eq("midrst_bg", bgcolour, 0);
        check_eq("midrst_pal", palette, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'hA3); send(8'h01);
        vs_pulse();
        check_eq("midrst_pal_after", palette, 1);
        check_eq("midrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
